// File: rtl/btb_rt_update_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btb_rt_update_queue_pkg                                            |
// | Branch-type encodings and queue entry layout for the retire queue. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package btb_rt_update_queue_pkg;

    localparam logic [1:0] BR_COND      = 2'd0;
    localparam logic [1:0] BR_UNCOND    = 2'd1;
    localparam logic [1:0] BR_INDIR_RAS = 2'd2;
    localparam logic [1:0] BR_INDIR_PC  = 2'd3;

    localparam int RTQ_ENTRY_W = 129;

    typedef struct packed {
        logic [63:0] brpc;
        logic [63:0] brtar;
        logic        brdir;
    } rtq_entry_t;

endpackage
`default_nettype wire

// File: rtl/btb_rt_update_queue_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rtq_fifo                                                           |
// | DEPTH x WIDTH synchronous FIFO, async active-low reset.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rtq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 129
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Full rejects a push even when a pop lands on the same edge.
    assign w_push = push_i && (count_q != C_FULL_CNT);
    assign w_pop  = pop_i  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == C_FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/btb_rt_update_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btb_rt_update_queue                                                |
// | Queues retired branch outcomes and drains them into the BTB.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module btb_rt_update_queue
    import btb_rt_update_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter bit FILTER_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rt_valid_i,
    input  logic [63:0] rt_brpc_i,
    input  logic [63:0] rt_brtar_i,
    input  logic        rt_brdir_i,
    input  logic [1:0]  rt_brtyp_i,
    output logic        rtq_full_o,
    output logic        rtq_empty_o,
    output logic        rtq_ovf_o,
    input  logic        rtq_ovf_clr_i,
    input  logic        btb_sp_we_i,
    input  logic        btb_hit_f1_i,
    output logic        btb_rt_we_o,
    output logic        btb_rt_brdir_o,
    output logic [63:0] btb_rt_brtar_o,
    output logic [63:0] btb_rt_brpc_o
);

    localparam int AW = $clog2(DEPTH);

    rtq_entry_t  w_din;
    rtq_entry_t  w_dout;
    rtq_entry_t  w_head;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_filt;
    logic        w_push_req;
    logic        w_sp_alloc;
    logic        w_rt_we;
    logic        ovf_q, ovf_d;

    // Taken direct unconditionals never change BTB state, so skip them.
    assign w_filt     = FILTER_EN && (rt_brtyp_i == BR_UNCOND) && rt_brdir_i;
    assign w_push_req = rt_valid_i && !w_filt;
    assign w_sp_alloc = btb_sp_we_i && !btb_hit_f1_i;
    assign w_rt_we    = (w_count != '0) && !w_sp_alloc;
    assign w_din      = {rt_brpc_i, rt_brtar_i, rt_brdir_i};

    rtq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RTQ_ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (w_push_req),
        .pop_i   (w_rt_we),
        .din_i   (w_din),
        .dout_o  (w_dout),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (w_push_req && w_full) ovf_d = 1'b1;
        else if (rtq_ovf_clr_i)   ovf_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign w_head         = w_empty ? '0 : w_dout;
    assign btb_rt_we_o    = w_rt_we;
    assign btb_rt_brpc_o  = w_head.brpc;
    assign btb_rt_brtar_o = w_head.brtar;
    assign btb_rt_brdir_o = w_head.brdir;
    assign rtq_full_o     = w_full;
    assign rtq_empty_o    = w_empty;
    assign rtq_ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_rt_update_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_btb_rt_update_queue                                             |
// | Scoreboard bench: queue-based reference model plus negedge monitor.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_btb_rt_update_queue;
    import btb_rt_update_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rt_valid_i;
    logic [63:0] rt_brpc_i;
    logic [63:0] rt_brtar_i;
    logic        rt_brdir_i;
    logic [1:0]  rt_brtyp_i;
    logic        rtq_full_o;
    logic        rtq_empty_o;
    logic        rtq_ovf_o;
    logic        rtq_ovf_clr_i;
    logic        btb_sp_we_i;
    logic        btb_hit_f1_i;
    logic        btb_rt_we_o;
    logic        btb_rt_brdir_o;
    logic [63:0] btb_rt_brtar_o;
    logic [63:0] btb_rt_brpc_o;

    btb_rt_update_queue #(.DEPTH(DEPTH), .FILTER_EN(1'b1)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rt_valid_i     (rt_valid_i),
        .rt_brpc_i      (rt_brpc_i),
        .rt_brtar_i     (rt_brtar_i),
        .rt_brdir_i     (rt_brdir_i),
        .rt_brtyp_i     (rt_brtyp_i),
        .rtq_full_o     (rtq_full_o),
        .rtq_empty_o    (rtq_empty_o),
        .rtq_ovf_o      (rtq_ovf_o),
        .rtq_ovf_clr_i  (rtq_ovf_clr_i),
        .btb_sp_we_i    (btb_sp_we_i),
        .btb_hit_f1_i   (btb_hit_f1_i),
        .btb_rt_we_o    (btb_rt_we_o),
        .btb_rt_brdir_o (btb_rt_brdir_o),
        .btb_rt_brtar_o (btb_rt_brtar_o),
        .btb_rt_brpc_o  (btb_rt_brpc_o)
    );

    always #5 clock = ~clock;

    rtq_entry_t sb[$];
    int         mdl_cnt = 0;
    bit         mdl_ovf = 1'b0;
    bit         mon_en  = 1'b0;
    int         total   = 0;
    int         bad     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance the abstract queue by one clock edge.
    task automatic model_step();
        bit filt, preq, spa, pop, acc;
        rtq_entry_t e;
        filt = (rt_brtyp_i == BR_UNCOND) && rt_brdir_i;
        preq = rt_valid_i && !filt;
        spa  = btb_sp_we_i && !btb_hit_f1_i;
        pop  = (mdl_cnt != 0) && !spa;
        acc  = preq && (mdl_cnt != DEPTH);
        if (preq && !acc)       mdl_ovf = 1'b1;
        else if (rtq_ovf_clr_i) mdl_ovf = 1'b0;
        if (acc) begin
            e.brpc = rt_brpc_i; e.brtar = rt_brtar_i; e.brdir = rt_brdir_i;
            sb.push_back(e);
        end
        mdl_cnt = mdl_cnt + int'(acc) - int'(pop);
    endtask

    task automatic cyc(input logic v, input logic [63:0] pc, input logic [63:0] tar,
                       input logic dir, input logic [1:0] typ,
                       input logic spwe, input logic hit, input logic clr);
        rt_valid_i = v; rt_brpc_i = pc; rt_brtar_i = tar; rt_brdir_i = dir;
        rt_brtyp_i = typ; btb_sp_we_i = spwe; btb_hit_f1_i = hit; rtq_ovf_clr_i = clr;
        @(posedge clock);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic idle(input logic spwe, input logic hit);
        cyc(1'b0, 64'h0, 64'h0, 1'b0, BR_COND, spwe, hit, 1'b0);
    endtask

    always @(negedge clock) begin : monitor
        logic       exp_we;
        rtq_entry_t h;
        if (mon_en) begin
            exp_we = (mdl_cnt != 0) && !(btb_sp_we_i && !btb_hit_f1_i);
            chk("we",    64'(btb_rt_we_o), 64'(exp_we));
            chk("empty", 64'(rtq_empty_o), 64'(mdl_cnt == 0));
            chk("full",  64'(rtq_full_o),  64'(mdl_cnt == DEPTH));
            chk("ovf",   64'(rtq_ovf_o),   64'(mdl_ovf));
            if (mdl_cnt == 0) begin
                chk("zero_pc",  btb_rt_brpc_o,        64'h0);
                chk("zero_tar", btb_rt_brtar_o,       64'h0);
                chk("zero_dir", 64'(btb_rt_brdir_o),  64'h0);
            end else if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'(mdl_cnt));
            end else begin
                h = sb[0];
                chk("head_pc",  btb_rt_brpc_o,       h.brpc);
                chk("head_tar", btb_rt_brtar_o,      h.brtar);
                chk("head_dir", 64'(btb_rt_brdir_o), 64'(h.brdir));
            end
            if (btb_rt_we_o && sb.size() != 0) void'(sb.pop_front());
        end
    end

    initial begin
        reset_n = 1'b0;
        rt_valid_i = 0; rt_brpc_i = 0; rt_brtar_i = 0; rt_brdir_i = 0; rt_brtyp_i = BR_COND;
        rtq_ovf_clr_i = 0; btb_sp_we_i = 0; btb_hit_f1_i = 0;
        #3;
        chk("rst_empty", 64'(rtq_empty_o), 64'h1);
        chk("rst_full",  64'(rtq_full_o),  64'h0);
        chk("rst_we",    64'(btb_rt_we_o), 64'h0);
        chk("rst_pc",    btb_rt_brpc_o,    64'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Basic drain
        cyc(1, 64'h1000, 64'h2000, 1, BR_COND, 0, 0, 0);
        idle(0, 0); idle(0, 0);

        // Collision stall, then non-allocating speculative write lets it drain
        cyc(1, 64'h3000, 64'h3100, 0, BR_COND, 1, 0, 0);
        repeat (3) idle(1, 0);
        idle(1, 1); idle(0, 0);

        // Fill and overflow under stall, then drain in order
        for (int k = 0; k < 9; k++)
            cyc(1, 64'h100 + 64'(4*k), 64'h9000 + 64'(k), k[0], BR_INDIR_PC, 1, 0, 0);
        repeat (9) idle(0, 0);
        cyc(0, 64'h0, 64'h0, 0, BR_COND, 0, 0, 1);

        // Filter
        cyc(1, 64'h4000, 64'h4100, 1, BR_UNCOND, 0, 0, 0);
        idle(0, 0);
        cyc(1, 64'h4200, 64'h4300, 0, BR_UNCOND, 0, 0, 0);
        idle(0, 0); idle(0, 0);

        // Concurrent push/pop
        for (int k = 0; k < 20; k++)
            cyc(1, 64'h5000 + 64'(8*k), 64'h6000 + 64'(k), 1, BR_COND, 0, 0, 0);
        idle(0, 0); idle(0, 0);

        // Reset mid-operation with a full queue and overflow set
        for (int k = 0; k < 9; k++)
            cyc(1, 64'h7000 + 64'(4*k), 64'h7800, 1, BR_COND, 1, 0, 0);
        rt_valid_i = 0; btb_sp_we_i = 0; btb_hit_f1_i = 0;
        #2;
        reset_n = 1'b0;
        sb.delete(); mdl_cnt = 0; mdl_ovf = 1'b0;
        #1;
        chk("mrst_we",    64'(btb_rt_we_o), 64'h0);
        chk("mrst_pc",    btb_rt_brpc_o,    64'h0);
        chk("mrst_tar",   btb_rt_brtar_o,   64'h0);
        chk("mrst_empty", 64'(rtq_empty_o), 64'h1);
        chk("mrst_ovf",   64'(rtq_ovf_o),   64'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        cyc(1, 64'h8000, 64'h8800, 1, BR_INDIR_RAS, 0, 0, 0);
        idle(0, 0); idle(0, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 19) == 0));

        // Bounded final drain
        for (int k = 0; k < 40 && mdl_cnt != 0; k++) idle(0, 0);
        idle(0, 0);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
